// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO that captures words from a serial receiver via a flag handshake.
// Optional sticky overrun flag enabled by defining UART_RX_FIFO_OVERRUN_FLAG_EN.
module uart_rx_fifo #(
  parameter int Nbit  = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [Nbit-1:0]          DataRx,
  input  logic                     Rx_flag,
  output logic                     clr_rx_flag,
  input  logic                     rd_en,
  output logic [Nbit-1:0]          rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {WAIT, CAPTURE, RELEASE} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [Nbit-1:0] storage [DEPTH];
  logic            wr_req, do_wr, do_rd;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      WAIT:    if (Rx_flag) state_next = CAPTURE;
      CAPTURE: state_next = RELEASE;
      RELEASE: if (!Rx_flag) state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT;
      clr_rx_flag <= 1'b1;
    end else begin
      state       <= state_next;
      clr_rx_flag <= (state_next != CAPTURE);
    end
  end

  // A read in the capture cycle frees the slot, so a full FIFO can still take the word.
  assign wr_req = (state == CAPTURE);
  assign do_rd  = rd_en && !empty;
  assign do_wr  = wr_req && (!full || rd_en);

  // NOTE: storage has no reset; entries are only visible once written and count says so.
  always_ff @(posedge clk) begin
    if (do_wr) storage[wr_ptr] <= DataRx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = empty ? '0 : storage[rd_ptr];

`ifdef UART_RX_FIFO_OVERRUN_FLAG_EN
  logic drop;
  assign drop = wr_req && full && !rd_en;

  // Setting wins over a simultaneous clear so a fresh drop is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end
`else
  logic unused_clr_overrun;
  assign unused_clr_overrun = clr_overrun;
  assign overrun            = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Nbit, default 8, data word width; matches the receiver word width.
REQ-002 DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 DataRx  input  Nbit  parallel word from the serial receiver; valid while Rx_flag=1.
REQ-006 Rx_flag  input  1  receiver "word available" flag; level, held until cleared.
REQ-007 clr_rx_flag  output  1  clear request to the receiver, active-low: 0 = clear, 1 = idle.
REQ-008 rd_en  input  1  CPU-side pop strobe, one word per cycle high.
REQ-009 rd_data  output  Nbit  head-of-FIFO word, first-word fall-through.
REQ-010 empty  output  1  FIFO holds zero words.
REQ-011 full  output  1  FIFO holds DEPTH words.
REQ-012 count  output  log2(DEPTH)+1  number of stored words.
REQ-013 overrun  output  1  sticky flag: a received word was dropped.
REQ-014 clr_overrun  input  1  synchronous clear of overrun, active-high.

Function
REQ-015 Capture FSM states: WAIT, CAPTURE, RELEASE.
REQ-016 WAIT: clr_rx_flag=1; Rx_flag=1 -> CAPTURE next cycle, else stay.
REQ-017 CAPTURE: lasts exactly one cycle; clr_rx_flag=0 (registered); DataRx written at the end of this cycle if not full, else the word is dropped and overrun set; -> RELEASE.
REQ-018 RELEASE: clr_rx_flag=1; Rx_flag=0 -> WAIT, else stay (no second capture of the same word).
REQ-019 clr_rx_flag never stays low for more than one consecutive cycle.
REQ-020 Latency: Rx_flag rising at edge N -> word visible on rd_data / empty=0 after edge N+2.
REQ-021 rd_data = storage[rd_ptr] when empty=0; rd_data = 0 when empty=1.
REQ-022 rd_en=1 with empty=0: rd_ptr advances, count decrements; rd_en with empty=1: ignored, no pointer or count change.
REQ-023 Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-024 Simultaneous write and read, not empty: both occur, count unchanged.
REQ-025 Simultaneous write and read while full: the read frees an entry and the write is accepted, no overrun.
REQ-026 Simultaneous write and read while empty: the write is accepted, the read is ignored, count becomes 1.
REQ-027 full = (count==DEPTH); empty = (count==0); both derived from registered count.
REQ-028 Priority between an overrun set and clr_overrun in the same cycle: the set wins.

Reset
REQ-029 reset=1 forces immediately: state=WAIT, clr_rx_flag=1, rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overrun=0, rd_data=0.
REQ-030 Storage contents need no reset; they are unobservable while empty=1.
REQ-031 Reset during CAPTURE aborts the write; a word still flagged after reset is captured through the normal WAIT path.

Configuration
REQ-032 Macro UART_RX_FIFO_OVERRUN_FLAG_EN: when defined, overrun behaves per REQ-013/017/028.
REQ-033 Without UART_RX_FIFO_OVERRUN_FLAG_EN: overrun is tied 0 and clr_overrun is ignored; a word received while full is still dropped and still cleared via clr_rx_flag.

Verification
REQ-034 After reset, Rx_flag=1 with DataRx=0xA5 -> clr_rx_flag=0 for exactly one cycle; then empty=0, count=1, rd_data=0xA5 two edges after the Rx_flag sample.
REQ-035 Write 0x01..0x08 with DEPTH=8 -> full=1, count=8; pop 8 times -> rd_data sequence 0x01..0x08, then empty=1, rd_data=0.
REQ-036 While full, receive 0x55 -> word dropped, overrun=1, count=8; clr_overrun=1 for one cycle -> overrun=0 (without the macro, overrun stays 0 throughout).
REQ-037 While full, assert rd_en in the CAPTURE cycle of 0x77 -> no overrun, count=8, 0x77 is the last word read.
REQ-038 Write 12 words while reading one per word, to force pointer wrap -> data order is preserved and count never exceeds 1.
REQ-039 Assert reset during CAPTURE -> all outputs at their REQ-029 values immediately; Rx_flag still high -> exactly one capture afterwards.
